// File: rtl/ram_dp_core_if.sv
// Write/read port bundle for ram_dp_core; master = agent side, slave = RAM side.
interface ram_dp_core_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_enb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;
    logic              req_drop;
    logic              rd_parity_err;

    modport master (
        output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        input  rd_data, rd_valid, init_busy, req_drop, rd_parity_err
    );

    modport slave (
        input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
        output rd_data, rd_valid, init_busy, req_drop, rd_parity_err
    );
endinterface

// File: rtl/ram_dp_core.sv
// Dual-port RAM, write-first, 1-cycle registered read; requests during the post-reset clear sweep are dropped (req_drop).
// Optional RAM_PARITY_EN stores an even-parity bit per word and flags mismatches on rd_parity_err.
module ram_dp_core #(
    parameter int                 ADDR_W   = 4,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    ram_dp_core_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              req_drop_q, req_drop_d;
    logic              par_err_q, par_err_d;
    logic              run;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wword;
    logic [MEM_W-1:0]  rd_word;
    logic              collide;

    assign run     = (state_q == ST_RUN);
    assign rd_word = mem[bus.rd_addr];
    assign collide = bus.wr_enb && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN: ;
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // The sweep owns the array write port; user writes only land in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wword = enc(bus.wr_data);
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wword = enc(INIT_VAL);
        end else if (run && bus.wr_enb) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wword;
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        par_err_d  = 1'b0;
        req_drop_d = !run && (bus.wr_enb || bus.rd_enb);
        if (run && bus.rd_enb) begin
            rd_valid_d = 1'b1;
            if (collide) begin
                rd_data_d = bus.wr_data;
            end else begin
                rd_data_d = rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
                par_err_d = rd_word[DATA_W] != (^rd_word[DATA_W-1:0]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            req_drop_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            req_drop_q <= req_drop_d;
            par_err_q  <= par_err_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.init_busy     = !run;
    assign bus.req_drop      = req_drop_q;
    assign bus.rd_parity_err = par_err_q;
endmodule
